// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared types, segment patterns and decode function for the digit scanner
//
// Contents:
//   scan_state_t  - scan FSM states (IDLE, DEAD, ON)
//   SEG_BLANK     - all segments dark
//   SEG_0..SEG_F  - active-low patterns, bit 0 = segment A .. bit 6 = segment G
//   seg_decode()  - 4-bit value to pattern; 10..15 are dark unless hex_en is set

package seven_segment_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        ON   = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    function automatic logic [6:0] seg_decode(input logic [3:0] value, input logic hex_en);
        logic [6:0] pattern;
        pattern = SEG_BLANK;
        case (value)
            4'h0: pattern = SEG_0;
            4'h1: pattern = SEG_1;
            4'h2: pattern = SEG_2;
            4'h3: pattern = SEG_3;
            4'h4: pattern = SEG_4;
            4'h5: pattern = SEG_5;
            4'h6: pattern = SEG_6;
            4'h7: pattern = SEG_7;
            4'h8: pattern = SEG_8;
            4'h9: pattern = SEG_9;
            4'hA: pattern = hex_en ? SEG_A : SEG_BLANK;
            4'hB: pattern = hex_en ? SEG_B : SEG_BLANK;
            4'hC: pattern = hex_en ? SEG_C : SEG_BLANK;
            4'hD: pattern = hex_en ? SEG_D : SEG_BLANK;
            4'hE: pattern = hex_en ? SEG_E : SEG_BLANK;
            4'hF: pattern = hex_en ? SEG_F : SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seven_segment_hex.sv
// rtl/seven_segment_hex.sv - combinational 4-bit to active-low seven-segment decoder
//
// Ports:
//   value   in  4 - digit value 0..15
//   hex_en  in  1 - 1 shows A..F for 10..15, 0 leaves them dark
//   seg     out 7 - active-low segments, seg[0]=A .. seg[6]=G

module seven_segment_hex
    import seven_segment_pkg::*;
(
    input  logic [3:0] value,
    input  logic       hex_en,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_decode(value, hex_en);
    end

endmodule

// File: rtl/seven_segment_scan.sv
// rtl/seven_segment_scan.sv - time-multiplexed common-anode digit scanner with dead time
//
// Parameters:
//   NUM_DIGITS  - digits scanned (>= 1)
//   ON_CYCLES   - cycles each digit is lit (>= 1)
//   DEAD_CYCLES - dark cycles ahead of each lit window (>= 1)
// Ports:
//   clk        in  1            - system clock
//   reset_n    in  1            - asynchronous active-low reset
//   digits     in  4*NUM_DIGITS - packed values, digit 0 in bits [3:0]
//   blank      in  NUM_DIGITS   - per-digit forced dark
//   hex_en     in  1            - decode 10..15 as A..F
//   lz_en      in  1            - leading-zero suppression
//   seg        out 7            - active-low segments (registered)
//   an         out NUM_DIGITS   - active-low digit enables (registered)
//   frame_tick out 1            - one-cycle pulse when a frame starts (registered)

module seven_segment_scan
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int ON_CYCLES   = 4096,
    parameter int DEAD_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    hex_en,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int MAX_CYCLES = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    scan_state_t state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          load;

    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic                    snap_hex;
    logic                    snap_lz;

    logic [NUM_DIGITS-1:0] supp;
    logic                  zero_run;
    logic [3:0]            cur_val;
    logic                  cur_dark;
    logic [6:0]            dec_seg;

    logic [6:0]            seg_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    // Walk from the most significant digit down; a digit is suppressed while
    // every digit from itself upward is zero. Digit 0 always shows.
    always_comb begin
        supp     = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (snap_digits[4*i +: 4] == 4'h0);
            if (i > 0) begin
                supp[i] = snap_lz && zero_run;
            end
        end
    end

    always_comb begin
        cur_val  = 4'h0;
        cur_dark = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_val  = snap_digits[4*i +: 4];
                cur_dark = snap_blank[i] | supp[i];
            end
        end
    end

    seven_segment_hex u_hex (
        .value  (cur_val),
        .hex_en (snap_hex),
        .seg    (dec_seg)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        load      = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = DEAD;
                idx_nxt   = '0;
                cnt_nxt   = '0;
                load      = 1'b1;
            end
            DEAD: begin
                if (cnt == DEAD_LAST) begin
                    state_nxt = ON;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ON: begin
                if (cnt == ON_LAST) begin
                    state_nxt = DEAD;
                    cnt_nxt   = '0;
                    if (idx == IDX_LAST) begin
                        idx_nxt = '0;
                        load    = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so they change on the same
    // edge as the FSM. idx is stable across any edge that enters or stays in
    // ON, so the current-idx decode is the right one. A value that decodes
    // dark (10..15 with hex off) also keeps its enable off.
    always_comb begin
        seg_nxt = SEG_BLANK;
        an_nxt  = '1;
        if (state_nxt == ON) begin
            seg_nxt = dec_seg;
            if (!cur_dark && (dec_seg != SEG_BLANK)) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx == IW'(i)) begin
                        an_nxt[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            snap_digits <= '0;
            snap_blank  <= '0;
            snap_hex    <= 1'b0;
            snap_lz     <= 1'b0;
            seg         <= SEG_BLANK;
            an          <= '1;
            frame_tick  <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            seg        <= seg_nxt;
            an         <= an_nxt;
            frame_tick <= load;
            if (load) begin
                snap_digits <= digits;
                snap_blank  <= blank;
                snap_hex    <= hex_en;
                snap_lz     <= lz_en;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// tb/tb_seven_segment_scan.sv - scoreboard bench for the 2-digit and 4-digit scanner

module tb_seven_segment_scan;

    localparam int DC = 2;
    localparam int OC = 4;

    localparam logic [6:0] SEGTAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [7:0]  d2;
    logic [1:0]  b2;
    logic        hx2, lz2;
    logic [6:0]  seg2;
    logic [1:0]  an2;
    logic        ft2;
    logic [15:0] d4;
    logic [3:0]  b4;
    logic        hx4, lz4;
    logic [6:0]  seg4;
    logic [3:0]  an4;
    logic        ft4;

    seven_segment_scan #(.NUM_DIGITS(2), .ON_CYCLES(OC), .DEAD_CYCLES(DC)) dut2 (
        .clk(clk), .reset_n(reset_n), .digits(d2), .blank(b2), .hex_en(hx2),
        .lz_en(lz2), .seg(seg2), .an(an2), .frame_tick(ft2)
    );

    seven_segment_scan #(.NUM_DIGITS(4), .ON_CYCLES(OC), .DEAD_CYCLES(DC)) dut4 (
        .clk(clk), .reset_n(reset_n), .digits(d4), .blank(b4), .hex_en(hx4),
        .lz_en(lz4), .seg(seg4), .an(an4), .frame_tick(ft4)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       tick;
    } exp_t;

    exp_t  q2[$];
    exp_t  q4[$];
    int    checks   = 0;
    int    failures = 0;
    string phase    = "reset";
    int    cyc      = 0;

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected {an, seg} for one lit slot, written from the digit rules.
    function automatic logic [10:0] model(input int n, input logic [15:0] dg, input logic [3:0] bl,
                                          input logic hx, input logic lz, input int idx);
        logic [3:0] val;
        logic [6:0] s;
        logic [3:0] a;
        logic       sup;
        val = dg[4*idx +: 4];
        s   = (val < 4'd10 || hx) ? SEGTAB[val] : 7'h7F;
        sup = lz && (idx > 0);
        for (int j = idx; j < n; j++) begin
            if (dg[4*j +: 4] != 4'h0) sup = 1'b0;
        end
        a = 4'hF;
        if (!(bl[idx] || sup || s == 7'h7F)) a[idx] = 1'b0;
        return {a, s};
    endfunction

    task automatic push_frame(input bit sel4, input int n, input logic [15:0] dg,
                              input logic [3:0] bl, input logic hx, input logic lz);
        exp_t e;
        for (int idx = 0; idx < n; idx++) begin
            for (int c = 0; c < DC; c++) begin
                e.an   = 4'hF;
                e.seg  = 7'h7F;
                e.tick = (idx == 0 && c == 0);
                if (sel4) q4.push_back(e); else q2.push_back(e);
            end
            for (int c = 0; c < OC; c++) begin
                {e.an, e.seg} = model(n, dg, bl, hx, lz, idx);
                e.tick = 1'b0;
                if (sel4) q4.push_back(e); else q2.push_back(e);
            end
        end
    endtask

    task automatic run(input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            if (q2.size() > 0) begin
                e = q2.pop_front();
                cmp($sformatf("%s_d2_an_c%0d", phase, cyc), {28'h0, 2'b11, an2}, {28'h0, e.an});
                cmp($sformatf("%s_d2_seg_c%0d", phase, cyc), {25'h0, seg2}, {25'h0, e.seg});
                cmp($sformatf("%s_d2_tick_c%0d", phase, cyc), {31'h0, ft2}, {31'h0, e.tick});
            end else begin
                checks++;
                failures++;
                $error("FAIL %s_d2_underflow_c%0d: got=empty expected=entry", phase, cyc);
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                cmp($sformatf("%s_d4_an_c%0d", phase, cyc), {28'h0, an4}, {28'h0, e.an});
                cmp($sformatf("%s_d4_seg_c%0d", phase, cyc), {25'h0, seg4}, {25'h0, e.seg});
                cmp($sformatf("%s_d4_tick_c%0d", phase, cyc), {31'h0, ft4}, {31'h0, e.tick});
            end else begin
                checks++;
                failures++;
                $error("FAIL %s_d4_underflow_c%0d: got=empty expected=entry", phase, cyc);
            end
            cyc++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        cmp({tag, "_seg2"}, {25'h0, seg2}, 32'h7F);
        cmp({tag, "_an2"},  {30'h0, an2},  32'h3);
        cmp({tag, "_ft2"},  {31'h0, ft2},  32'h0);
        cmp({tag, "_seg4"}, {25'h0, seg4}, 32'h7F);
        cmp({tag, "_an4"},  {28'h0, an4},  32'hF);
        cmp({tag, "_ft4"},  {31'h0, ft4},  32'h0);
    endtask

    initial begin
        // Reset held with arbitrary inputs.
        reset_n = 1'b0;
        d2 = 8'($urandom); b2 = 2'($urandom); hx2 = 1'($urandom); lz2 = 1'($urandom);
        d4 = 16'($urandom); b4 = 4'($urandom); hx4 = 1'($urandom); lz4 = 1'($urandom);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Window 1: scan timing 8'h52; leading-zero suppression on 16'h0030.
        phase = "scan"; cyc = 0;
        d2 = 8'h52;   b2 = 2'b00;   hx2 = 1'b1; lz2 = 1'b0;
        d4 = 16'h0030; b4 = 4'b0000; hx4 = 1'b1; lz4 = 1'b1;
        reset_n = 1'b1;
        push_frame(1'b0, 2, {8'h00, d2}, {2'b00, b2}, hx2, lz2);
        push_frame(1'b0, 2, {8'h00, d2}, {2'b00, b2}, hx2, lz2);
        push_frame(1'b1, 4, d4, b4, hx4, lz4);
        run(24);

        // Window 2: hex digits A/F; blank digit 0 on top of suppression.
        phase = "hexon"; cyc = 0;
        d2 = 8'hAF; hx2 = 1'b1;
        b4 = 4'b0001;
        push_frame(1'b0, 2, {8'h00, d2}, {2'b00, b2}, hx2, lz2);
        push_frame(1'b0, 2, {8'h00, d2}, {2'b00, b2}, hx2, lz2);
        push_frame(1'b1, 4, d4, b4, hx4, lz4);
        run(24);

        // Window 3: hex off darkens A/F; four nonzero-topped digits.
        phase = "hexoff"; cyc = 0;
        hx2 = 1'b0;
        d4 = 16'h9E07; b4 = 4'b0000; hx4 = 1'b1; lz4 = 1'b1;
        push_frame(1'b0, 2, {8'h00, d2}, {2'b00, b2}, hx2, lz2);
        push_frame(1'b0, 2, {8'h00, d2}, {2'b00, b2}, hx2, lz2);
        push_frame(1'b1, 4, d4, b4, hx4, lz4);
        run(24);

        // Window 4: digits change during digit 0 lit slot; all-zero with lz.
        phase = "midchg"; cyc = 0;
        d2 = 8'h52; hx2 = 1'b1;
        d4 = 16'h0000; lz4 = 1'b1;
        push_frame(1'b0, 2, 16'h0052, 4'b0000, 1'b1, 1'b0);
        push_frame(1'b0, 2, 16'h0038, 4'b0000, 1'b1, 1'b0);
        push_frame(1'b1, 4, d4, b4, hx4, lz4);
        run(4);
        d2 = 8'h38;
        run(20);

        // Window 5: reset asserted while digit 0 is lit.
        phase = "midrst"; cyc = 0;
        push_frame(1'b0, 2, {8'h00, d2}, {2'b00, b2}, hx2, lz2);
        push_frame(1'b1, 4, d4, b4, hx4, lz4);
        run(4);
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("midrst_async");
        q2.delete();
        q4.delete();
        @(negedge clk);
        check_reset_outputs("midrst_held");

        // Window 6: restart from edge 0 with fresh values.
        phase = "restart"; cyc = 0;
        d2 = 8'hC0; b2 = 2'b00; hx2 = 1'b1; lz2 = 1'b1;
        d4 = 16'h00B0; b4 = 4'b0100; hx4 = 1'b1; lz4 = 1'b1;
        reset_n = 1'b1;
        push_frame(1'b0, 2, {8'h00, d2}, {2'b00, b2}, hx2, lz2);
        push_frame(1'b0, 2, {8'h00, d2}, {2'b00, b2}, hx2, lz2);
        push_frame(1'b1, 4, d4, b4, hx4, lz4);
        run(24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
